// File: rtl/ascii_num_parser.sv
// Turns a raw UART byte stream into decimal integer tokens with end-of-line markers,
// buffered in a small FIFO because the byte source cannot be stalled.
module ascii_num_parser #(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             num_valid,
   input  logic             num_ready,
   output logic [WIDTH-1:0] num_value,
   output logic             num_has_val,
   output logic             num_eol,
   output logic             num_sat,
   output logic             dropped
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = WIDTH + 3;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic {IDLE, DIGITS} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] acc, acc_next;
   logic             sat, sat_next;
   logic             push;
   logic [TW-1:0]    tok;

   logic [TW-1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;
   logic             pop, push_ok, empty;
   logic [TW-1:0]    head;

   logic is_digit, is_lf, is_cr;

   // Multiply-accumulate one decimal digit; top bit flags overflow past WIDTH bits.
   function automatic logic [WIDTH:0] mac_sat(input logic [WIDTH-1:0] a, input logic [3:0] d);
      logic [WIDTH+3:0] wide;
      wide = {4'b0000, a} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, d};
      if (wide[WIDTH+3:WIDTH] != 4'd0)
         mac_sat = {1'b1, {WIDTH{1'b1}}};
      else
         mac_sat = {1'b0, wide[WIDTH-1:0]};
   endfunction

   assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign is_lf    = (in_data == 8'h0A);
   assign is_cr    = (in_data == 8'h0D);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         sat   <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         sat   <= sat_next;
      end
   end

   always_comb begin
      state_next = state;
      if (in_valid) begin
         if (is_digit)
            state_next = DIGITS;
         else if (!is_cr)
            state_next = IDLE;
      end
   end

   always_comb begin
      logic [WIDTH:0]   m;
      logic [WIDTH-1:0] acc_base;
      logic             sat_base;
      acc_next = acc;
      sat_next = sat;
      push     = 1'b0;
      tok      = '0;
      acc_base = (state == DIGITS) ? acc : '0;
      sat_base = (state == DIGITS) ? sat : 1'b0;
      m        = mac_sat(acc_base, in_data[3:0]);
      if (in_valid) begin
         if (is_digit) begin
            acc_next = m[WIDTH-1:0];
            sat_next = sat_base | m[WIDTH];
         end else if (is_lf) begin
            push     = 1'b1;
            tok      = (state == DIGITS) ? {sat, 1'b1, 1'b1, acc} : {1'b0, 1'b1, 1'b0, {WIDTH{1'b0}}};
            acc_next = '0;
            sat_next = 1'b0;
         end else if (!is_cr) begin
            push     = (state == DIGITS);
            tok      = {sat, 1'b0, 1'b1, acc};
            acc_next = '0;
            sat_next = 1'b0;
         end
      end
   end

   // Token FIFO: fullness is judged after a same-cycle pop, so a full FIFO can pop and push together.
   assign empty   = (count == '0);
   assign pop     = num_ready && !empty;
   assign push_ok = push && !((count == FULL_CNT) && !pop);

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= tok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         dropped <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
         if (push && !push_ok)
            dropped <= 1'b1;
      end
   end

   assign head        = empty ? '0 : mem[rd_ptr];
   assign num_valid   = !empty;
   assign num_value   = head[WIDTH-1:0];
   assign num_has_val = head[WIDTH];
   assign num_eol     = head[WIDTH+1];
   assign num_sat     = head[WIDTH+2];

endmodule
